// File: rtl/ringbus_pkg.sv
// Shared ring bus constants and transmit arbiter state encoding.
// Imported by every ring bus arbiter slice.
package ringbus_pkg;

  localparam int RB_ADDR_W = 32;
  localparam int RB_DATA_W = 32;

  localparam int DONE_TIMEOUT_DEF = 4096;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set request after `last`.
// Search order is last+1 .. N-1, then 0 .. last.
module rr_select #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant_onehot,
  output logic [IW-1:0] grant_idx
);

  logic w_found;
  int   w_j;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    w_found      = 1'b0;
    w_j          = 0;
    for (int k = 1; k <= N; k++) begin
      w_j = int'(last) + k;
      if (w_j >= N) w_j = w_j - N;
      if (!w_found && req[w_j[IW-1:0]]) begin
        w_found                      = 1'b1;
        grant_idx                    = w_j[IW-1:0];
        grant_onehot[w_j[IW-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ringbus_tx_arbiter.sv
// Round-robin share of the ring bus transmit port between requesters.
// One write in flight; completion or timeout frees the port.
module ringbus_tx_arbiter
  import ringbus_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DONE_TIMEOUT = DONE_TIMEOUT_DEF
) (
  input  logic                           clk,
  input  logic                           srst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*RB_ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*RB_DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             req_done,
  output logic [NUM_REQ-1:0]             req_timeout,
  output logic [RB_ADDR_W-1:0]           rb_wr_addr,
  output logic [RB_DATA_W-1:0]           rb_wr_data,
  output logic                           rb_start_wr,
  input  logic                           rb_write_ready,
  input  logic                           rb_done_wr,
  output logic                           busy,
  output logic [7:0]                     timeout_count
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(DONE_TIMEOUT);

  logic [1:0]           r_state;
  logic [IW-1:0]        r_last;
  logic [IW-1:0]        r_gidx;
  logic [RB_ADDR_W-1:0] r_addr;
  logic [RB_DATA_W-1:0] r_data;
  logic [CW-1:0]        r_cnt;
  logic [7:0]           r_tcnt;

  logic [NUM_REQ-1:0]   w_sel_oh;
  logic [IW-1:0]        w_sel_idx;
  logic [RB_ADDR_W-1:0] w_addr;
  logic [RB_DATA_W-1:0] w_data;
  logic [NUM_REQ-1:0]   w_g_oh;
  logic                 w_grant;
  logic                 w_in_wait;
  logic                 w_done;
  logic                 w_tmo;

  rr_select #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req          (req_valid),
    .last         (r_last),
    .grant_onehot (w_sel_oh),
    .grant_idx    (w_sel_idx)
  );

  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel_oh[i]) begin
        w_addr = req_addr[i*RB_ADDR_W +: RB_ADDR_W];
        w_data = req_data[i*RB_DATA_W +: RB_DATA_W];
      end
    end
  end

  // Pulses are gated by srst so an aborted write never reports back.
  assign w_grant   = (r_state == ST_IDLE) && (|req_valid)
                     && rb_write_ready && !srst;
  assign w_in_wait = (r_state == ST_WAIT) && !srst;
  assign w_done    = w_in_wait && rb_done_wr;
  assign w_tmo     = w_in_wait && !rb_done_wr
                     && (r_cnt == CW'(DONE_TIMEOUT - 1));
  assign w_g_oh    = NUM_REQ'(1) << r_gidx;

  assign req_ready     = w_grant ? w_sel_oh : '0;
  assign req_done      = w_done ? w_g_oh : '0;
  assign req_timeout   = w_tmo ? w_g_oh : '0;
  assign rb_start_wr   = (r_state == ST_ISSUE);
  assign busy          = (r_state != ST_IDLE);
  assign rb_wr_addr    = r_addr;
  assign rb_wr_data    = r_data;
  assign timeout_count = r_tcnt;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_state <= ST_IDLE;
      r_last  <= IW'(NUM_REQ - 1);
      r_gidx  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_tcnt  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_addr  <= w_addr;
            r_data  <= w_data;
            r_gidx  <= w_sel_idx;
            r_last  <= w_sel_idx;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_done) begin
            r_state <= ST_IDLE;
          end else if (w_tmo) begin
            r_state <= ST_IDLE;
            if (r_tcnt != 8'hFF) r_tcnt <= r_tcnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
